eth_axi_wr_sub: RTL

//  AXI4 write-channel subordinate: the responder end of the AXI write traffic that a

---
 rtl/eth_axi_wr_sub_if.sv | 45 ++++
 rtl/eth_axi_wr_sub.sv | 134 +++++++++++++
 2 files changed

// File: rtl/eth_axi_wr_sub_if.sv
// AXI4 write-channel bundle (AW, W, B) between a master and
// the Ethernet-side write subordinate.
interface eth_axi_wr_sub_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 8
);
    localparam int SW = DW / 8;

    logic [IW-1:0] aw_id_i;
    logic [AW-1:0] aw_addr_i;
    logic [7:0]    aw_len_i;
    logic [1:0]    aw_burst_i;
    logic          aw_valid_i;
    logic          aw_ready_o;

    logic [DW-1:0] w_data_i;
    logic [SW-1:0] w_strb_i;
    logic          w_last_i;
    logic          w_valid_i;
    logic          w_ready_o;

    logic [IW-1:0] b_id_o;
    logic [1:0]    b_resp_o;
    logic          b_valid_o;
    logic          b_ready_i;

    modport slave (
        input  aw_id_i, aw_addr_i, aw_len_i, aw_burst_i, aw_valid_i,
        output aw_ready_o,
        input  w_data_i, w_strb_i, w_last_i, w_valid_i,
        output w_ready_o,
        output b_id_o, b_resp_o, b_valid_o,
        input  b_ready_i
    );

    modport master (
        output aw_id_i, aw_addr_i, aw_len_i, aw_burst_i, aw_valid_i,
        input  aw_ready_o,
        output w_data_i, w_strb_i, w_last_i, w_valid_i,
        input  w_ready_o,
        input  b_id_o, b_resp_o, b_valid_o,
        output b_ready_i
    );
endinterface

// File: rtl/eth_axi_wr_sub.sv
// AXI4 write subordinate: one burst at a time into a word-wide
// buffer, one B response per burst.
module eth_axi_wr_sub #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ID_WIDTH   = 8,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        DEPTH          = 256,
    localparam int SW = AXI_DATA_WIDTH / 8,
    localparam int MW = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    eth_axi_wr_sub_if.slave           bus,
    output logic                      mem_we_o,
    output logic [MW-1:0]             mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0] mem_wdata_o,
    output logic [SW-1:0]             mem_be_o
);
    localparam int AW  = AXI_ADDR_WIDTH;
    localparam int IW  = AXI_ID_WIDTH;
    localparam int LSB = $clog2(SW);

    // Window bounds carry one extra bit so the top never overflows.
    localparam logic [AW:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [AW:0] WIN_SZ = (AW+1)'(DEPTH * SW);
    localparam logic [AW:0] WIN_HI = WIN_LO + WIN_SZ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_RESP
    } state_t;

    state_t        state;
    logic          rdy_q;
    logic [IW-1:0] id_q;
    logic [7:0]    len_q;
    logic          inc_q;
    logic [7:0]    cnt_q;
    logic [MW-1:0] ptr_q;
    logic          err_q;

    logic [AW:0]   aw_ext;
    logic [MW-1:0] aw_word;
    logic [MW+8:0] aw_last;
    logic          aw_out;
    logic          aw_err;
    logic          aw_hs;
    logic          w_hs;
    logic          is_last;

    // The base is window-aligned, so the low address bits already
    // give the word offset inside the window.
    assign aw_ext  = {1'b0, bus.aw_addr_i};
    assign aw_word = bus.aw_addr_i[LSB +: MW];
    assign aw_last = (MW+9)'(aw_word) + (MW+9)'(bus.aw_len_i);
    assign aw_out  = (aw_ext < WIN_LO) || (aw_ext >= WIN_HI);
    assign aw_err  = aw_out
                   || bus.aw_burst_i[1]
                   || ((bus.aw_burst_i == 2'b01)
                       && (aw_last >= (MW+9)'(DEPTH)));

    assign aw_hs   = bus.aw_valid_i && bus.aw_ready_o;
    assign w_hs    = bus.w_valid_i && bus.w_ready_o;
    assign is_last = (cnt_q == len_q);

    // Burst sequencing: capture AW, count W beats, hold B until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            rdy_q <= 1'b0;
            id_q  <= '0;
            len_q <= '0;
            inc_q <= 1'b0;
            cnt_q <= '0;
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (aw_hs) begin
                        id_q  <= bus.aw_id_i;
                        len_q <= bus.aw_len_i;
                        inc_q <= (bus.aw_burst_i == 2'b01);
                        ptr_q <= aw_word;
                        cnt_q <= '0;
                        err_q <= aw_err;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (inc_q) begin
                            ptr_q <= ptr_q + MW'(1);
                        end
                        if (bus.w_last_i != is_last) begin
                            err_q <= 1'b1;
                        end
                        if (is_last) begin
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.b_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        bus.aw_ready_o = (state == S_IDLE) && rdy_q;
        bus.w_ready_o  = (state == S_DATA);
        bus.b_valid_o  = (state == S_RESP);
        bus.b_id_o     = id_q;
        bus.b_resp_o   = {(state == S_RESP) && err_q, 1'b0};
    end

    // Buffer port: write in the beat's own cycle, data gated off
    // outside DATA so reset and idle show all zeros.
    always_comb begin
        mem_we_o    = w_hs && !err_q && (|bus.w_strb_i);
        mem_addr_o  = ptr_q;
        mem_wdata_o = (state == S_DATA) ? bus.w_data_i : '0;
        mem_be_o    = (state == S_DATA) ? bus.w_strb_i : '0;
    end
endmodule
